// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte (CSUM state).
package imem_loader_pkg;

   localparam int LEN_BYTE_W     = 8;
   localparam int LEN_W          = 2 * LEN_BYTE_W;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = WORD_W / 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_CSUM
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_WRITE,
      ST_DONE
   } state_t;
`endif

   // States in which an incoming byte may be consumed.
   function automatic logic accepts_byte(input state_t s);
      logic r;
      r = 1'b0;
      case (s)
         ST_LEN0, ST_LEN1, ST_DATA: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four little-endian bytes into one 32-bit word.
// The first byte received ends up in word[7:0]; last flags the fourth byte of a word.
module byte_packer (
   input  logic        clock,
   input  logic        rst,
   input  logic        clr,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        last
);
   import imem_loader_pkg::*;

   logic [7:0] lane_reg [BYTES_PER_WORD];
   logic [7:0] lane_next [BYTES_PER_WORD];
   logic [1:0] cnt_reg;

   // Each lane takes the byte from the lane above; the top lane takes the new byte.
   for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == BYTES_PER_WORD - 1) begin : g_top
         assign lane_next[gi] = byte_in;
      end else begin : g_mid
         assign lane_next[gi] = lane_reg[gi + 1];
      end

      always_ff @(posedge clock) begin
         if (rst) begin
            lane_reg[gi] <= 8'h00;
         end else if (load) begin
            lane_reg[gi] <= lane_next[gi];
         end
      end

      assign word[8*gi +: 8] = lane_reg[gi];
   end

   always_ff @(posedge clock) begin
      if (rst || clr) begin
         cnt_reg <= 2'd0;
      end else if (load) begin
         cnt_reg <= cnt_reg + 2'd1;
      end
   end

   assign last = load && (cnt_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian byte image into instruction memory.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W      = 30,
   parameter int DEPTH_WORDS = 256
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);
   import imem_loader_pkg::*;

   localparam logic [LEN_W:0] DEPTH_LIM = (LEN_W + 1)'(DEPTH_WORDS);

   state_t                  state_reg;
   logic [LEN_BYTE_W-1:0]   len_lo_reg;
   logic [LEN_W-1:0]        len_reg;
   logic [LEN_W-1:0]        word_cnt_reg;
   logic                    wr_en_reg;
   logic [ADDR_W-1:0]       wr_addr_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    error_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]              csum_reg;
`endif

   logic              xfer;
   logic              start_ok;
   logic              pack_load;
   logic              pack_last;
   logic [LEN_W-1:0]  len_word;
   logic [LEN_W-1:0]  word_cnt_inc;
   logic [31:0]       pack_word;

   assign byte_ready   = accepts_byte(state_reg);
   assign xfer         = byte_valid && byte_ready;
   assign start_ok     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign pack_load    = xfer && (state_reg == ST_DATA);
   assign len_word     = {byte_data, len_lo_reg};
   assign word_cnt_inc = word_cnt_reg + 1'b1;

   byte_packer u_packer (
      .clock   (clock),
      .rst     (rst),
      .clr     (start_ok),
      .load    (pack_load),
      .byte_in (byte_data),
      .word    (pack_word),
      .last    (pack_last)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         len_lo_reg   <= '0;
         len_reg      <= '0;
         word_cnt_reg <= '0;
         wr_en_reg    <= 1'b0;
         wr_addr_reg  <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_reg     <= 8'h00;
`endif
      end else begin
         wr_en_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg    <= ST_LEN0;
                  busy_reg     <= 1'b1;
                  done_reg     <= 1'b0;
                  error_reg    <= 1'b0;
                  word_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg     <= 8'h00;
`endif
               end
            end
            ST_LEN0: begin
               if (xfer) begin
                  len_lo_reg <= byte_data;
                  state_reg  <= ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (xfer) begin
                  len_reg <= len_word;
                  if (len_word == '0) begin
                     state_reg <= ST_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else if ({1'b0, len_word} > DEPTH_LIM) begin
                     // Oversized image is refused before any memory write.
                     state_reg <= ST_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     error_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg <= csum_reg ^ byte_data;
`endif
                  if (pack_last) begin
                     state_reg   <= ST_WRITE;
                     wr_en_reg   <= 1'b1;
                     wr_addr_reg <= ADDR_W'(word_cnt_reg);
                  end
               end
            end
            ST_WRITE: begin
               word_cnt_reg <= word_cnt_inc;
               if (word_cnt_inc >= len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_reg <= ST_CSUM;
`else
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
`endif
               end else begin
                  state_reg <= ST_DATA;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (xfer) begin
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  error_reg <= (byte_data != csum_reg);
               end
            end
`endif
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_en    = wr_en_reg;
   assign wr_addr  = wr_addr_reg;
   assign wr_data  = pack_word;
   assign busy     = busy_reg;
   assign cpu_hold = busy_reg;
   assign done     = done_reg;
   assign error    = error_reg;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 30, meaning the word-address width (byte address bits [31:2]).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the instruction memory capacity in 32-bit words.
REQ-003 The block SHALL have port clock  input  1  meaning the single system clock; all logic rising-edge.
REQ-004 The block SHALL have port rst  input  1  meaning the synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  meaning the single-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 The block SHALL have port byte_valid  input  1  meaning the incoming byte is valid.
REQ-007 The block SHALL have port byte_data  input  8  meaning the incoming byte.
REQ-008 The block SHALL have port byte_ready  output  1  meaning the block accepts a byte this cycle (transfer = byte_valid & byte_ready).
REQ-009 The block SHALL have port wr_en  output  1  meaning the memory write strobe.
REQ-010 The block SHALL have port wr_addr  output  ADDR_W  meaning the memory word address.
REQ-011 The block SHALL have port wr_data  output  32  meaning the memory write word.
REQ-012 The block SHALL have port cpu_hold  output  1  meaning the processor is held in reset while loading.
REQ-013 The block SHALL have port busy  output  1  meaning the block is in any state other than IDLE or DONE.
REQ-014 The block SHALL have port done  output  1  meaning the load has finished (sticky until start or rst).
REQ-015 The block SHALL have port error  output  1  meaning the load was rejected or failed (sticky until start or rst).

Function
REQ-016 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, WRITE, DONE (plus CSUM when configured).
REQ-017 start SHALL move the FSM from IDLE/DONE to LEN0 the next cycle and clear done, error, word counter and byte counter.
REQ-018 LEN0/LEN1 SHALL each accept one byte forming 16-bit word count N, little-endian (LEN0 = low byte).
REQ-019 On leaving LEN1: N == 0 SHALL go to DONE with error=0; N > DEPTH_WORDS SHALL go to DONE with error=1 and no writes; else go to DATA.
REQ-020 DATA SHALL accept four bytes per word, little-endian (first byte -> wr_data[7:0]).
REQ-021 After the fourth byte transfer, the FSM SHALL enter WRITE; wr_en SHALL be high for exactly that one cycle, with wr_addr = word index (0..N-1) and wr_data stable.
REQ-022 byte_ready SHALL be 1 only in LEN0, LEN1, DATA (and CSUM); 0 in IDLE, WRITE, DONE.
REQ-023 After WRITE, the FSM SHALL return to DATA if words written < N, else go to DONE (or CSUM when configured).
REQ-024 Throughput: one word per 5 cycles with byte_valid held high.
REQ-025 The word counter SHALL never exceed N; wr_addr SHALL never exceed DEPTH_WORDS-1.
REQ-026 cpu_hold SHALL equal busy; done SHALL assert on the cycle DONE is entered.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, cpu_hold=0, done=0, error=0, all counters 0.
REQ-029 rst mid-load SHALL abort the load within the same edge; no further wr_en SHALL occur; partial memory contents are left as written.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, after the last WRITE the FSM SHALL enter CSUM, accept one byte, and set error=1 if it differs from the XOR of all data bytes; then DONE.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN, no CSUM state SHALL exist and the last WRITE SHALL go directly to DONE.

Structure
REQ-032 A shared package imem_loader_pkg SHALL hold the FSM state enum and the LEN byte width constant.
REQ-033 A sub-module byte_packer (4-byte-to-word shift register with byte counter) is natural and SHALL be used.

Verification
REQ-034 start, N=2, bytes 13 00 00 00 | 93 00 10 00 -> wr_en at addr 0 data 00000013, addr 1 data 00100093; done=1, error=0.
REQ-035 N=DEPTH_WORDS+1 (0x0101 at default) -> no wr_en, done=1, error=1, cpu_hold released.
REQ-036 byte_valid toggled every other cycle during N=1 -> same single write as continuous stream; no byte lost or duplicated.
REQ-037 rst asserted after 2 of 3 words written -> IDLE next cycle, wr_en stays 0; new start then completes normally.
REQ-038 IMEM_LOADER_CHECKSUM_EN defined, N=1, data 13 00 00 00, checksum 0x12 -> error=1; checksum 0x13 -> error=0.
REQ-039 N=0 -> DONE after LEN1, error=0, zero writes; start asserted while busy -> ignored.
